// File: rtl/lpf_window_feeder_if.sv
// Sample-in / window-out handshake bundle between the mixer path, the feeder and the integrator.
// master = feeder side, slave = producer/consumer side.
interface lpf_window_feeder_if #(
  parameter int ARRAY_SIZE = 8,
  parameter int DATA_WIDTH = 18
);
  localparam int FW = $clog2(ARRAY_SIZE + 1);

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_sample;
  logic [DATA_WIDTH-1:0] window_array [0:ARRAY_SIZE-1];
  logic                  window_valid;
  logic                  window_ready;
  logic [FW-1:0]         fill_count;

  modport master (
    input  in_valid, in_sample, window_ready,
    output in_ready, window_array, window_valid, fill_count
  );

  modport slave (
    output in_valid, in_sample, window_ready,
    input  in_ready, window_array, window_valid, fill_count
  );
endinterface

// File: rtl/lpf_window_feeder.sv
// Shifts accepted samples into an ARRAY_SIZE tap line and presents it as a held window
// once full, then every DECIMATION accepts.
module lpf_window_feeder #(
  parameter int ARRAY_SIZE = 8,
  parameter int DATA_WIDTH = 18,
  parameter int DECIMATION = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  lpf_window_feeder_if.master  bus
);
  localparam int FW = $clog2(ARRAY_SIZE + 1);

  typedef enum logic [1:0] {FILL, STREAM, HOLD} state_t;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] tap_q [0:ARRAY_SIZE-1];
  logic [DATA_WIDTH-1:0] tap_d [0:ARRAY_SIZE-1];
  logic [FW-1:0]         fill_q;
  logic [7:0]            cnt_q;
  logic                  wv_q;
  logic                  accept;
  logic                  complete;

  assign bus.in_ready     = ~wv_q | bus.window_ready;
  assign accept           = bus.in_valid & bus.in_ready;
  assign complete         = wv_q & bus.window_ready;
  assign bus.window_valid = wv_q;
  assign bus.fill_count   = fill_q;
  assign bus.window_array = tap_q;

  // Shifted line: newest at index 0, oldest falls off the end.
  always_comb begin
    tap_d[0] = bus.in_sample;
    for (int i = 1; i < ARRAY_SIZE; i++) tap_d[i] = tap_q[i-1];
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < ARRAY_SIZE; i++) tap_q[i] <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
      wv_q    <= 1'b0;
      state_q <= FILL;
    end else begin
      case (state_q)
        FILL: if (accept) begin
          tap_q  <= tap_d;
          fill_q <= fill_q + FW'(1);
          if (fill_q == FW'(ARRAY_SIZE - 1)) begin
            wv_q    <= 1'b1;
            cnt_q   <= '0;
            state_q <= HOLD;
          end
        end
        STREAM: if (accept) begin
          tap_q <= tap_d;
          if (cnt_q == 8'(DECIMATION - 1)) begin
            wv_q    <= 1'b1;
            cnt_q   <= '0;
            state_q <= HOLD;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        HOLD: if (complete) begin
          // An accept here is the first sample of the next decimation period.
          if (accept) begin
            tap_q <= tap_d;
            if (DECIMATION == 1) begin
              wv_q <= 1'b1;
            end else begin
              wv_q    <= 1'b0;
              cnt_q   <= 8'd1;
              state_q <= STREAM;
            end
          end else begin
            wv_q    <= 1'b0;
            state_q <= STREAM;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end
endmodule

// File: tb/tb_lpf_window_feeder.sv
// Directed test of lpf_window_feeder: fill, decimation, backpressure, flush, DECIMATION=1 streaming.
module tb_lpf_window_feeder;
  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  lpf_window_feeder_if #(.ARRAY_SIZE(8), .DATA_WIDTH(18)) ifa ();
  lpf_window_feeder_if #(.ARRAY_SIZE(8), .DATA_WIDTH(18)) ifb ();

  lpf_window_feeder #(.ARRAY_SIZE(8), .DATA_WIDTH(18), .DECIMATION(8)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .bus(ifa.master)
  );
  lpf_window_feeder #(.ARRAY_SIZE(8), .DATA_WIDTH(18), .DECIMATION(1)) dut_b (
    .clk(clk), .rst(rst), .flush(1'b0), .bus(ifb.master)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    ifa.in_valid = 1'b1; ifa.in_sample = 18'h3FFFF; ifa.window_ready = 1'b0;
    ifb.in_valid = 1'b0; ifb.in_sample = '0;        ifb.window_ready = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < 8; i++) chk($sformatf("rst_arr%0d", i), 32'(ifa.window_array[i]), 32'h0);
    chk("rst_fill", 32'(ifa.fill_count), 32'd0);
    chk("rst_wv", 32'(ifa.window_valid), 32'd0);
    chk("rst_rdy", 32'(ifa.in_ready), 32'd1);

    // First fill: 8 accepts of k<<10
    rst = 1'b0; ifa.window_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      ifa.in_sample = 18'(k << 10);
      tick();
      if (k < 8) begin
        chk($sformatf("fill_wv%0d", k), 32'(ifa.window_valid), 32'd0);
        chk($sformatf("fill_cnt%0d", k), 32'(ifa.fill_count), 32'(k));
      end
    end
    chk("w1_wv", 32'(ifa.window_valid), 32'd1);
    chk("w1_a0", 32'(ifa.window_array[0]), 32'h02000);
    chk("w1_a7", 32'(ifa.window_array[7]), 32'h00400);
    chk("w1_fill", 32'(ifa.fill_count), 32'd8);

    // Decimation: k=9..16, window after the 16th
    for (int k = 9; k <= 16; k++) begin
      ifa.in_sample = 18'(k << 10);
      tick();
      if (k < 16) chk($sformatf("dec_wv%0d", k), 32'(ifa.window_valid), 32'd0);
    end
    chk("w2_wv", 32'(ifa.window_valid), 32'd1);
    chk("w2_a0", 32'(ifa.window_array[0]), 32'h04000);
    chk("w2_a7", 32'(ifa.window_array[7]), 32'h02400);

    // Backpressure: window held, input stalled
    ifa.window_ready = 1'b0; ifa.in_sample = 18'h01234;
    #1 chk("bp_rdy0", 32'(ifa.in_ready), 32'd0);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("bp_wv%0d", c), 32'(ifa.window_valid), 32'd1);
      chk($sformatf("bp_rdy%0d", c), 32'(ifa.in_ready), 32'd0);
      chk($sformatf("bp_a0_%0d", c), 32'(ifa.window_array[0]), 32'h04000);
      chk($sformatf("bp_a7_%0d", c), 32'(ifa.window_array[7]), 32'h02400);
    end
    ifa.window_ready = 1'b1;
    tick();
    chk("bp_rel_wv", 32'(ifa.window_valid), 32'd0);
    chk("bp_rel_a0", 32'(ifa.window_array[0]), 32'h01234);
    chk("bp_rel_a1", 32'(ifa.window_array[1]), 32'h04000);
    // Counter resumed at 1: exactly 7 more accepts raise the next window
    for (int i = 0; i < 7; i++) begin
      ifa.in_sample = 18'(32'h100 + i);
      tick();
      if (i < 6) chk($sformatf("post_wv%0d", i), 32'(ifa.window_valid), 32'd0);
    end
    chk("w3_wv", 32'(ifa.window_valid), 32'd1);
    chk("w3_a0", 32'(ifa.window_array[0]), 32'h00106);
    chk("w3_a7", 32'(ifa.window_array[7]), 32'h01234);

    // Flush discards the pending window and drops the offered sample
    flush = 1'b1; ifa.in_sample = 18'h00777;
    tick();
    flush = 1'b0;
    chk("fl_wv", 32'(ifa.window_valid), 32'd0);
    chk("fl_fill", 32'(ifa.fill_count), 32'd0);
    chk("fl_a0", 32'(ifa.window_array[0]), 32'h0);

    // Flush mid-fill
    for (int i = 1; i <= 5; i++) begin
      ifa.in_sample = 18'(32'h10 + i);
      tick();
    end
    chk("mf_fill5", 32'(ifa.fill_count), 32'd5);
    ifa.in_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("mf_fill0", 32'(ifa.fill_count), 32'd0);
    chk("mf_a0", 32'(ifa.window_array[0]), 32'h0);
    chk("mf_a4", 32'(ifa.window_array[4]), 32'h0);
    ifa.in_valid = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      ifa.in_sample = (i == 1) ? 18'h20001 : 18'(32'h20 + i);
      tick();
      if (i < 8) chk($sformatf("mf_wv%0d", i), 32'(ifa.window_valid), 32'd0);
    end
    chk("mf_wv8", 32'(ifa.window_valid), 32'd1);
    chk("mf_a0_8", 32'(ifa.window_array[0]), 32'h00028);
    chk("mf_a7_8", 32'(ifa.window_array[7]), 32'h20001);
    ifa.in_valid = 1'b0;

    // DECIMATION=1: window every cycle after the first
    ifb.in_valid = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      ifb.in_sample = 18'(k);
      tick();
      if (k < 8) chk($sformatf("d1_wv%0d", k), 32'(ifb.window_valid), 32'd0);
      else begin
        chk($sformatf("d1_wv%0d", k), 32'(ifb.window_valid), 32'd1);
        chk($sformatf("d1_a0_%0d", k), 32'(ifb.window_array[0]), 32'(k));
        chk($sformatf("d1_a7_%0d", k), 32'(ifb.window_array[7]), 32'(k - 7));
      end
    end
    ifb.in_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
